// File: rtl/game_strobe_multi.sv
// Purpose : n_channels independent programmable-period strobe timers (periodic or one-shot).
// Latency : arm at edge E0 with enable high -> first strobe registered at edge E(period).
// Backpr. : none; the global enable pauses every channel, and each paused cycle delays its strobe by one cycle.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   enable          global count enable (low = pause all channels)
//   arm[i]          start/restart channel i (ignored when its period is 0)
//   stop[i]         cancel channel i (wins over arm)
//   one_shot[i]     1 = fire once then idle, 0 = periodic
//   period          channel i period = period[i*width +: width], in enabled cycles
//   strobe[i]       registered one-cycle pulse per channel
//   busy[i]         registered; high while channel i is in RUN
module game_strobe_multi #(
   parameter int width      = 32,
   parameter int n_channels = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [n_channels-1:0]         arm,
   input  logic [n_channels-1:0]         stop,
   input  logic [n_channels-1:0]         one_shot,
   input  logic [n_channels*width-1:0]   period,
   output logic [n_channels-1:0]         strobe,
   output logic [n_channels-1:0]         busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

   genvar i;
   generate
      for (i = 0; i < n_channels; i++) begin : g_ch
         state_t           state;
         state_t           state_nxt;
         logic [width-1:0] count;
         logic [width-1:0] count_nxt;
         logic             strobe_q;
         logic             strobe_nxt;
         logic [width-1:0] per;
         logic             per_zero;
         logic             count_zero;

         // Period and mode are sampled live; they only matter at arm or reload,
         // so a change mid-count never disturbs the running count.
         assign per        = period[i*width +: width];
         assign per_zero   = (per == '0);
         assign count_zero = (count == '0);

         // Priority: stop > arm > count. The counter is parked at 0 in IDLE.
         always_comb begin
            state_nxt  = state;
            count_nxt  = count;
            strobe_nxt = 1'b0;

            if (stop[i]) begin
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (arm[i]) begin
               // Arm restarts even from RUN and swallows any strobe due this edge.
               if (per_zero) begin
                  state_nxt = IDLE;
                  count_nxt = '0;
               end else begin
                  state_nxt = RUN;
                  count_nxt = per - one;
               end
            end else if (state == RUN && enable) begin
               if (!count_zero) begin
                  count_nxt = count - one;
               end else begin
                  // Terminal count: the strobe fires even if the channel then stops
                  // because it is one-shot or its period was cleared to 0.
                  strobe_nxt = 1'b1;
                  if (one_shot[i] || per_zero) begin
                     state_nxt = IDLE;
                     count_nxt = '0;
                  end else begin
                     count_nxt = per - one;
                  end
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state    <= IDLE;
               count    <= '0;
               strobe_q <= 1'b0;
            end else begin
               state    <= state_nxt;
               count    <= count_nxt;
               strobe_q <= strobe_nxt;
            end
         end

         assign strobe[i] = strobe_q;
         assign busy[i]   = (state == RUN);
      end
   endgenerate

endmodule

// File: tb/tb_game_strobe_multi.sv
// Purpose : directed self-checking bench for game_strobe_multi (width=8, 4 channels).
// Latency : expected strobe edges are queued when stimulus is driven and matched per cycle.
// Backpr. : n/a; every wait is bounded by cycle number and a global watchdog.
module tb_game_strobe_multi;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [N-1:0]   arm;
   logic [N-1:0]   stop;
   logic [N-1:0]   one_shot;
   logic [N*W-1:0] period;
   logic [N-1:0]   strobe;
   logic [N-1:0]   busy;

   int cyc      = 0;
   int n_assert = 0;
   int n_fail   = 0;
   int exp_q[$];
   int e0;
   int pers[N] = '{2, 3, 5, 7};

   game_strobe_multi #(.width(W), .n_channels(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .arm      (arm),
      .stop     (stop),
      .one_shot (one_shot),
      .period   (period),
      .strobe   (strobe),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; at a falling edge it names the edge
   // whose registered outputs are currently visible.
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every strobe must match a queued (cycle, channel) entry and
   // every queued entry must see its strobe in exactly that cycle.
   always @(negedge clk) begin
      for (int ch = 0; ch < N; ch++) begin
         int key;
         int idx;
         key = cyc * N + ch;
         idx = -1;
         for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k] == key) idx = k;
         if (strobe[ch] === 1'b1 || idx >= 0) begin
            n_assert++;
            assert (strobe[ch] === 1'b1 && idx >= 0) else begin
               n_fail++;
               $error("FAIL strobe_ch%0d at cycle %0d: observed %b expected %0d", ch, cyc, strobe[ch], (idx >= 0));
            end
            if (idx >= 0) exp_q.delete(idx);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   function automatic void expect_strobe(input int ch, input int c);
      exp_q.push_back(c * N + ch);
   endfunction

   task automatic set_per(input int ch, input int v);
      logic [W-1:0] pv;
      pv = v[W-1:0];
      period[ch*W +: W] = pv;
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b1;
      arm      = '0;
      stop     = '0;
      one_shot = '0;
      period   = '0;

      // Reset for 3 edges, then idle with no arm.
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("reset_strobe", strobe, 0);
         chk("reset_busy", busy, 0);
      end
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("idle_strobe", strobe, 0);
         chk("idle_busy", busy, 0);
      end

      // Periodic ch0, period 3: strobes at E3, E6, E9.
      set_per(0, 3);
      one_shot[0] = 1'b0;
      arm[0] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(0, e0 + 3);
      expect_strobe(0, e0 + 6);
      expect_strobe(0, e0 + 9);
      tick(1);
      arm[0] = 1'b0;
      chk("periodic_busy", busy[0], 1);
      wait_cyc(e0 + 9);
      stop[0] = 1'b1;
      tick(1);
      stop[0] = 1'b0;
      chk("periodic_stopped", busy[0], 0);

      // One-shot ch1, period 5, enable low at E2 and E3: single strobe at E7.
      set_per(1, 5);
      one_shot[1] = 1'b1;
      arm[1] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(1, e0 + 7);
      tick(1);
      arm[1] = 1'b0;
      wait_cyc(e0 + 1);
      enable = 1'b0;
      wait_cyc(e0 + 3);
      chk("pause_busy", busy[1], 1);
      enable = 1'b1;
      wait_cyc(e0 + 6);
      chk("oneshot_busy_before", busy[1], 1);
      tick(1);
      chk("oneshot_strobe", strobe[1], 1);
      chk("oneshot_busy_after", busy[1], 0);
      tick(10);
      chk("oneshot_idle", busy[1], 0);

      // Priority ch2, period 4: arm on the terminal edge restarts, stop beats arm.
      set_per(2, 4);
      one_shot[2] = 1'b0;
      arm[2] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(2, e0 + 8);
      tick(1);
      arm[2] = 1'b0;
      wait_cyc(e0 + 3);
      arm[2] = 1'b1;
      tick(1);
      arm[2] = 1'b0;
      chk("rearm_busy", busy[2], 1);
      wait_cyc(e0 + 11);
      stop[2] = 1'b1;
      arm[2]  = 1'b1;
      tick(1);
      stop[2] = 1'b0;
      arm[2]  = 1'b0;
      chk("stop_over_arm_busy", busy[2], 0);
      tick(8);

      // Period 1 on ch3: continuously high from E1.
      set_per(3, 1);
      one_shot[3] = 1'b0;
      arm[3] = 1'b1;
      e0 = cyc + 1;
      for (int k = 1; k <= 10; k++) expect_strobe(3, e0 + k);
      tick(1);
      arm[3] = 1'b0;
      wait_cyc(e0 + 10);
      stop[3] = 1'b1;
      tick(1);
      stop[3] = 1'b0;
      chk("p1_stopped", busy[3], 0);
      tick(3);

      // Period 0 arm on ch0 is ignored.
      set_per(0, 0);
      arm[0] = 1'b1;
      tick(1);
      arm[0] = 1'b0;
      chk("p0_busy", busy[0], 0);
      tick(3);
      chk("p0_busy_later", busy[0], 0);

      // Period cleared to 0 while running ch1: final strobe fires, then IDLE.
      set_per(1, 2);
      one_shot[1] = 1'b0;
      arm[1] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(1, e0 + 2);
      tick(1);
      arm[1] = 1'b0;
      wait_cyc(e0 + 1);
      set_per(1, 0);
      wait_cyc(e0 + 2);
      chk("p_cleared_busy", busy[1], 0);
      tick(5);

      // Maximum period 255 on ch2.
      set_per(2, 255);
      arm[2] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(2, e0 + 255);
      expect_strobe(2, e0 + 510);
      tick(1);
      arm[2] = 1'b0;
      wait_cyc(e0 + 300);
      chk("pmax_busy", busy[2], 1);
      wait_cyc(e0 + 510);
      stop[2] = 1'b1;
      tick(1);
      stop[2] = 1'b0;
      chk("pmax_stopped", busy[2], 0);

      // All channels, periods 2/3/5/7, then reset at E17 (no strobe due there).
      one_shot = '0;
      for (int ch = 0; ch < N; ch++) set_per(ch, pers[ch]);
      arm = '1;
      e0 = cyc + 1;
      for (int ch = 0; ch < N; ch++)
         for (int m = pers[ch]; m <= 16; m += pers[ch])
            expect_strobe(ch, e0 + m);
      tick(1);
      arm = '0;
      chk("multi_busy", busy, 4'hF);
      wait_cyc(e0 + 16);
      reset = 1'b1;
      tick(1);
      chk("midreset_strobe", strobe, 0);
      chk("midreset_busy", busy, 0);
      tick(1);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("post_reset_busy", busy, 0);
      end

      // Re-arm after reset works again.
      arm[0] = 1'b1;
      e0 = cyc + 1;
      expect_strobe(0, e0 + 2);
      tick(1);
      arm[0] = 1'b0;
      wait_cyc(e0 + 2);
      stop[0] = 1'b1;
      tick(1);
      stop[0] = 1'b0;
      tick(2);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
